// File: rtl/toggle_link_rx_pkg.sv
// Shared types and widths for the clock-plus-toggle link receiver.
//   state_t  : FSM encoding reported on the state output (3 is unused).
//   GOOD_W   : width of the wrapping good-sample counter.
//   ERR_W    : width of the saturating error counter.
//   PERIOD_W : width of the strobe period measurement.
//   ERR_MAX  : saturation value of the error counter.
package toggle_link_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned GOOD_W   = 16;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned PERIOD_W = 8;

  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/toggle_link_rx_if.sv
// Pad-side inputs and status outputs of the toggle link receiver.
//   master : drives rx_strobe, rx_toggle, clear; observes status.
//   slave  : the receiver; samples the inputs, drives locked, err, state,
//            good_cnt, err_cnt and period.
interface toggle_link_rx_if;
  import toggle_link_rx_pkg::*;

  logic                rx_strobe;
  logic                rx_toggle;
  logic                clear;
  logic                locked;
  logic                err;
  logic [1:0]          state;
  logic [GOOD_W-1:0]   good_cnt;
  logic [ERR_W-1:0]    err_cnt;
  logic [PERIOD_W-1:0] period;

  modport master (
    output rx_strobe, rx_toggle, clear,
    input  locked, err, state, good_cnt, err_cnt, period
  );

  modport slave (
    input  rx_strobe, rx_toggle, clear,
    output locked, err, state, good_cnt, err_cnt, period
  );

endinterface

// File: rtl/toggle_link_sync.sv
// Multi-flop synchronizer for an asynchronous pad input.
//   clk, rst_n : local clock, asynchronous active-low reset (flops reset to 0).
//   d          : asynchronous input.
//   q          : synchronized level (SYNC_STAGES flops deep).
//   fall       : one-cycle pulse when q goes 1->0 (tied 0 when EDGE_EN=0).
module toggle_link_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= q;
      end
      assign fall = prev & ~q;
    end else begin : g_level
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/toggle_link_rx.sv
// Receiver/checker for the forwarded-clock plus toggle diagnostic link.
// Synchronizes strobe and toggle, samples the toggle on each strobe falling
// edge, locks after LOCK_COUNT consecutive alternating samples and counts
// good samples and mismatches while locked.
//   clk, rst_n : local clock, asynchronous active-low reset.
//   link       : toggle_link_rx_if.slave (rx_strobe, rx_toggle, clear in;
//                locked, err, state, good_cnt, err_cnt, period out).
// Optional feature: define TOGGLE_LINK_RX_PERIOD_EN to measure the strobe
// period in local cycles; otherwise period reads 0.
module toggle_link_rx
  import toggle_link_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  toggle_link_rx_if.slave  link
);

  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  logic fall_pulse;
  logic strobe_level_unused;
  logic tog_sync;
  logic tog_fall_unused;

  toggle_link_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_strobe_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (link.rx_strobe),
    .q    (strobe_level_unused),
    .fall (fall_pulse)
  );

  toggle_link_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_toggle_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (link.rx_toggle),
    .q    (tog_sync),
    .fall (tog_fall_unused)
  );

  state_t            state_q;
  logic              locked_q;
  logic              err_q;
  logic              last_tog;
  logic [7:0]        run;
  logic [15:0]       tmo;
  logic [GOOD_W-1:0] good_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              good_sample;

  assign good_sample = tog_sync ^ last_tog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      last_tog <= 1'b0;
      run      <= '0;
      tmo      <= '0;
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (!(state_q inside {IDLE, ACQ, LOCKED})) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
        tmo      <= '0;
      end else if (fall_pulse) begin
        // A sample beats a coincident timeout: process it and restart the timer.
        tmo      <= '0;
        last_tog <= tog_sync;
        case (state_q)
          IDLE: begin
            run     <= '0;
            state_q <= ACQ;
          end
          ACQ: begin
            if (good_sample) begin
              if (run == LOCK_LAST) begin
                run      <= '0;
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                run <= run + 8'd1;
              end
            end else begin
              run <= '0;
            end
          end
          default: begin
            if (good_sample) begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end else begin
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
              err_q    <= 1'b1;
              run      <= '0;
              state_q  <= ACQ;
              locked_q <= 1'b0;
            end
          end
        endcase
      end else if (state_q != IDLE) begin
        if (tmo == TMO_LAST) begin
          tmo      <= '0;
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end else begin
          tmo <= tmo + 16'd1;
        end
      end

      // Placed last so a coincident increment is overridden.
      if (link.clear) begin
        good_cnt <= '0;
        err_cnt  <= '0;
        err_q    <= 1'b0;
      end
    end
  end

  assign link.locked   = locked_q;
  assign link.err      = err_q;
  assign link.state    = state_q;
  assign link.good_cnt = good_cnt;
  assign link.err_cnt  = err_cnt;

`ifdef TOGGLE_LINK_RX_PERIOD_EN
  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] period_q;

  // per_cnt holds the cycles elapsed since the previous fall_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt  <= '0;
      period_q <= '0;
    end else if (fall_pulse) begin
      period_q <= per_cnt;
      per_cnt  <= PERIOD_W'(1);
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + PERIOD_W'(1);
    end
  end

  assign link.period = period_q;
`else
  assign link.period = '0;
`endif

endmodule
